// File: rtl/conv1_calc_if.sv
// conv1_calc_if
// Bundles the window input, weight-write port and feature-map output of
// conv1_calc.
//   master : window source / weight loader (drives valid_in, pixel_0..8,
//            wt_we, wt_addr, wt_data; observes valid_out, fmap_out,
//            frame_done)
//   slave  : the convolution datapath (the opposite directions)
interface conv1_calc_if #(
  parameter int N_FILTERS = 4,
  parameter int W_BITS    = 8,
  parameter int OUT_BITS  = 8,
  parameter int ADDR_BITS = $clog2(N_FILTERS * 10)
) ();
  logic                          valid_in;
  logic                          pixel_0;
  logic                          pixel_1;
  logic                          pixel_2;
  logic                          pixel_3;
  logic                          pixel_4;
  logic                          pixel_5;
  logic                          pixel_6;
  logic                          pixel_7;
  logic                          pixel_8;
  logic                          wt_we;
  logic [ADDR_BITS-1:0]          wt_addr;
  logic [W_BITS-1:0]             wt_data;
  logic                          valid_out;
  logic [N_FILTERS*OUT_BITS-1:0] fmap_out;
  logic                          frame_done;

  modport master (
    output valid_in, pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, wt_we, wt_addr, wt_data,
    input  valid_out, fmap_out, frame_done
  );

  modport slave (
    input  valid_in, pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
           pixel_5, pixel_6, pixel_7, pixel_8, wt_we, wt_addr, wt_data,
    output valid_out, fmap_out, frame_done
  );
endinterface

// File: rtl/conv1_calc.sv
// conv1_calc
// First-layer convolution: each valid 3x3 binary window is multiplied
// against N_FILTERS sets of signed 3x3 weights plus a bias, passed through
// ReLU and unsigned saturation, and emitted three cycles later as one
// OUT_BITS sample per filter. Output beats are counted so the last sample of
// each (IN_WIDTH-2)x(IN_HEIGHT-2) feature map is flagged with frame_done.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (clears pipeline, counter, weights)
//   bus  : conv1_calc_if.slave (window in, weight writes, feature-map out)
module conv1_calc #(
  parameter int N_FILTERS = 4,
  parameter int W_BITS    = 8,
  parameter int OUT_BITS  = 8,
  parameter int IN_WIDTH  = 28,
  parameter int IN_HEIGHT = 28
) (
  input  logic         clk,
  input  logic         rst,
  conv1_calc_if.slave  bus
);

  localparam int N_WTS     = N_FILTERS * 10;
  localparam int ADDR_BITS = $clog2(N_WTS);
  // 9 taps plus bias of W_BITS each never exceed W_BITS+4 bits signed.
  localparam int ACC_BITS  = W_BITS + 4;
  localparam int N_SAMPLES = (IN_WIDTH - 2) * (IN_HEIGHT - 2);
  localparam int CNT_BITS  = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(N_SAMPLES - 1);

  // Sign-extend a weight to accumulator width.
  function automatic logic signed [ACC_BITS-1:0] sext(input logic [W_BITS-1:0] w);
    return {{(ACC_BITS - W_BITS){w[W_BITS-1]}}, w};
  endfunction

  // ReLU followed by clamp to the unsigned output range.
  function automatic logic [OUT_BITS-1:0] relu_sat(input logic signed [ACC_BITS-1:0] a);
    logic [OUT_BITS-1:0] r;
    if (a[ACC_BITS-1]) begin
      r = '0;
    end else if (|a[ACC_BITS-2:OUT_BITS]) begin
      r = '1;
    end else begin
      r = a[OUT_BITS-1:0];
    end
    return r;
  endfunction

  logic [W_BITS-1:0]             wt_q [N_WTS];
  logic [8:0]                    pix_s;
  logic                          s1_valid_q;
  logic [8:0]                    s1_pix_q;
  logic                          s2_valid_q;
  logic signed [ACC_BITS-1:0]    acc_d [N_FILTERS];
  logic signed [ACC_BITS-1:0]    acc_q [N_FILTERS];
  logic [N_FILTERS*OUT_BITS-1:0] fmap_d;
  logic [N_FILTERS*OUT_BITS-1:0] fmap_q;
  logic                          valid_out_q;
  logic                          frame_done_d;
  logic                          frame_done_q;
  logic [CNT_BITS-1:0]           cnt_d;
  logic [CNT_BITS-1:0]           cnt_q;

  assign pix_s = {bus.pixel_8, bus.pixel_7, bus.pixel_6, bus.pixel_5, bus.pixel_4,
                  bus.pixel_3, bus.pixel_2, bus.pixel_1, bus.pixel_0};

  // Weight file; addresses at or beyond N_WTS match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_WTS; i++) begin
        wt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_WTS; i++) begin
        if (bus.wt_we && (bus.wt_addr == ADDR_BITS'(i))) begin
          wt_q[i] <= bus.wt_data;
        end
      end
    end
  end

  // Stage 1: capture the window and its valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
    end else begin
      s1_valid_q <= bus.valid_in;
      s1_pix_q   <= pix_s;
    end
  end

  // Stage 2 datapath: binary pixels gate each tap into the biased sum. The
  // weight file is read here, so a write landing on the capture edge is seen.
  always_comb begin
    for (int f = 0; f < N_FILTERS; f++) begin
      acc_d[f] = sext(wt_q[f*10 + 9]);
      for (int k = 0; k < 9; k++) begin
        if (s1_pix_q[k]) begin
          acc_d[f] = acc_d[f] + sext(wt_q[f*10 + k]);
        end else begin
          acc_d[f] = acc_d[f];
        end
      end
    end
  end

  // Stage 2 register: accumulators and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      for (int f = 0; f < N_FILTERS; f++) begin
        acc_q[f] <= '0;
      end
    end else begin
      s2_valid_q <= s1_valid_q;
      for (int f = 0; f < N_FILTERS; f++) begin
        acc_q[f] <= acc_d[f];
      end
    end
  end

  // Stage 3 datapath: clamp outputs, advance the map counter on valid beats
  // and flag the beat that completes a map. Idle cycles drive zero data.
  always_comb begin
    fmap_d       = '0;
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    if (s2_valid_q) begin
      for (int f = 0; f < N_FILTERS; f++) begin
        fmap_d[f*OUT_BITS +: OUT_BITS] = relu_sat(acc_q[f]);
      end
      if (cnt_q == CNT_MAX) begin
        frame_done_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d        = cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
      end
    end else begin
      fmap_d       = '0;
      frame_done_d = 1'b0;
      cnt_d        = cnt_q;
    end
  end

  // Stage 3 register: outputs and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_q  <= 1'b0;
      fmap_q       <= '0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_out_q  <= s2_valid_q;
      fmap_q       <= fmap_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.valid_out  = valid_out_q;
  assign bus.fmap_out   = fmap_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv1_calc.sv
// Testbench for conv1_calc: directed windows with hand-computed expected
// feature-map words pushed to a scoreboard; an independent monitor pops and
// compares each output beat (data, frame_done, latency).
module tb_conv1_calc;

  localparam int MAP_BEATS = 676;

  typedef struct {
    logic [31:0] fmap;
    logic        fd;
    int          issue_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   beats;
  int   fd_seen;
  int   unexpected;
  exp_t sb[$];

  conv1_calc_if #(.N_FILTERS(4), .W_BITS(8), .OUT_BITS(8)) bus ();

  conv1_calc #(
    .N_FILTERS(4), .W_BITS(8), .OUT_BITS(8), .IN_WIDTH(28), .IN_HEIGHT(28)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One input cycle; a valid beat pushes its expected output.
  task automatic drive(input bit v, input logic [8:0] pix, input bit we,
                       input logic [5:0] addr, input logic [7:0] data,
                       input logic [31:0] expv);
    exp_t e;
    @(negedge clk);
    bus.valid_in = v;
    bus.pixel_0 = pix[0]; bus.pixel_1 = pix[1]; bus.pixel_2 = pix[2];
    bus.pixel_3 = pix[3]; bus.pixel_4 = pix[4]; bus.pixel_5 = pix[5];
    bus.pixel_6 = pix[6]; bus.pixel_7 = pix[7]; bus.pixel_8 = pix[8];
    bus.wt_we   = we;
    bus.wt_addr = addr;
    bus.wt_data = data;
    if (v) begin
      beats++;
      e.fmap      = expv;
      e.fd        = ((beats % MAP_BEATS) == 0);
      e.issue_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [8:0] pix, input logic [31:0] expv);
    drive(1'b1, pix, 1'b0, 6'd0, 8'd0, expv);
  endtask

  task automatic wr(input logic [5:0] addr, input logic [7:0] data);
    drive(1'b0, 9'd0, 1'b1, addr, data, 32'd0);
  endtask

  task automatic idle();
    drive(1'b0, 9'd0, 1'b0, 6'd0, 8'd0, 32'd0);
  endtask

  // Monitor: compare each output beat against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (bus.frame_done) fd_seen++;
    if (bus.valid_out) begin
      if (sb.size() == 0) begin
        unexpected++;
        check(1'b0, "unexpected_beat", {31'd0, bus.valid_out}, 32'd0);
      end else begin
        e = sb.pop_front();
        check(bus.fmap_out == e.fmap, "fmap", bus.fmap_out, e.fmap);
        check(bus.frame_done == e.fd, "frame_done", {31'd0, bus.frame_done}, {31'd0, e.fd});
        check((cyc - e.issue_cyc) == 3, "latency", 32'(cyc - e.issue_cyc), 32'd3);
      end
    end else if (!rst) begin
      check(bus.fmap_out == 32'd0 && !bus.frame_done, "idle_zero",
            {bus.fmap_out[30:0], bus.frame_done}, 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; checks = 0; errors = 0; beats = 0; fd_seen = 0; unexpected = 0;
    rst = 1'b1;
    bus.valid_in = 1'b1;
    bus.pixel_0 = 1'b1; bus.pixel_1 = 1'b1; bus.pixel_2 = 1'b1;
    bus.pixel_3 = 1'b1; bus.pixel_4 = 1'b1; bus.pixel_5 = 1'b1;
    bus.pixel_6 = 1'b1; bus.pixel_7 = 1'b1; bus.pixel_8 = 1'b1;
    bus.wt_we = 1'b0; bus.wt_addr = 6'd0; bus.wt_data = 8'd0;

    // Reset held with an active all-ones window: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(!bus.valid_out, "rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
      check(bus.fmap_out == 32'd0, "rst_fmap", bus.fmap_out, 32'd0);
      check(!bus.frame_done, "rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    end
    rst = 1'b0;
    beats++;
    sb.push_back('{32'h0000_0000, 1'b0, cyc});   // first beat, weights all zero
    idle();

    // Filter 0: taps 1, bias 0.
    for (int k = 0; k < 9; k++) wr(6'(k), 8'd1);
    send(9'h1FF, 32'h0000_0009);
    send(9'b101010101, 32'h0000_0005);

    // Filter 1: taps -20, bias 5 (ReLU clamp).
    for (int k = 0; k < 9; k++) wr(6'(10 + k), 8'hEC);
    wr(6'd19, 8'd5);
    send(9'h1FF, 32'h0000_0009);
    send(9'h000, 32'h0000_0500);

    // Filter 2: taps 127, bias 127 (saturation), then taps -128.
    for (int k = 0; k < 10; k++) wr(6'(20 + k), 8'h7F);
    send(9'h1FF, 32'h00FF_0009);
    send(9'h000, 32'h007F_0500);
    for (int k = 0; k < 9; k++) wr(6'(20 + k), 8'h80);
    send(9'b000010000, 32'h0000_0001);

    // Filter 3 bias written on the capture edge of the second window.
    send(9'h000, 32'h007F_0500);
    drive(1'b1, 9'h000, 1'b1, 6'd39, 8'd10, 32'h0A7F_0500);
    // A write one edge after capture must not reach that sample.
    send(9'h000, 32'h0A7F_0500);
    wr(6'd39, 8'd20);
    send(9'h000, 32'h147F_0500);

    // Out-of-range addresses change nothing.
    wr(6'd40, 8'h55);
    wr(6'd63, 8'h55);
    send(9'h1FF, 32'h1400_0009);
    send(9'h000, 32'h147F_0500);
    for (int i = 0; i < 6; i++) idle();

    // Mid-stream reset with samples in flight.
    send(9'h1FF, 32'h1400_0009);
    send(9'h1FF, 32'h1400_0009);
    send(9'h1FF, 32'h1400_0009);
    #1;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    sb.delete();
    beats = 0;
    #1;
    check(!bus.valid_out && bus.fmap_out == 32'd0 && !bus.frame_done, "async_rst",
          {bus.fmap_out[30:0], bus.valid_out}, 32'd0);
    idle(); idle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) idle();
    check(unexpected == 0, "flushed_after_rst", 32'(unexpected), 32'd0);

    // Reload filter 0 taps and filter 3 bias (weights cleared by reset).
    for (int k = 0; k < 9; k++) wr(6'(k), 8'd1);
    wr(6'd39, 8'd10);
    fd_seen = 0;

    // Two full maps plus one beat, in 26-beat rows with 2 idle cycles.
    for (int b = 0; b < 2 * MAP_BEATS + 1; b++) begin
      if (b % 2 == 0) send(9'h1FF, 32'h0A00_0009);
      else            send(9'b101010101, 32'h0A00_0005);
      if ((b + 1) % 26 == 0) begin
        idle(); idle();
      end
    end
    idle();

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
    check(sb.size() == 0, "drain", 32'(sb.size()), 32'd0);
    check(fd_seen == 2, "frame_pulses", 32'(fd_seen), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
